decode_issue_ctrl: RTL and testbench

Sequencing controller in front of the instruction decoder. Buffers fetched instructions in a 2-entry queue, presents the head instruction (with its PC) to the decode/execute boundary under a valid/ready handshake, and inserts a one-cycle bubble on RV64 load-use hazards. Also handles pipeline flushes and flags unrecognised opcodes. Sits between the fetch unit and the combinational decoder/EX stage.

---
 rtl/decode_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// Issue controller between fetch and the decoder: a 2-entry instruction queue with RV64 load-use bubbling.
// Build option: define DECODE_HAZARD_CHK_EN to include the load tracker, bubble insertion and stall_cnt.
module decode_issue_ctrl #(
    parameter int PC_W  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_ready,
    output logic             id_valid,
    output logic [31:0]      id_instr,
    output logic [PC_W-1:0]  id_pc,
    output logic             id_illegal,
    input  logic             ex_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_IMM    = 7'b0010011,
        OP_IMM32  = 7'b0011011,
        OP_REG    = 7'b0110011,
        OP_REG32  = 7'b0111011
    } opcode_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t      mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  cnt;
    logic        push;
    logic        pop;
    logic        haz;
    logic        not_empty;
    logic        illegal;
    entry_t      head;

    assign head      = mem[rd_ptr];
    assign not_empty = (cnt != 2'd0);
    assign if_ready  = (cnt != 2'd2);
    assign id_valid  = not_empty & ~haz;
    assign push      = if_valid & if_ready & ~flush;
    assign pop       = id_valid & ex_ready & ~flush;

    assign id_instr   = not_empty ? head.instr : 32'd0;
    assign id_pc      = not_empty ? head.pc : {PC_W{1'b0}};
    assign id_illegal = not_empty & illegal;

    always_comb begin
        // NOTE: default first so every path assigns illegal and no latch is inferred.
        illegal = 1'b1;
        case (head.instr[6:0])
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
            OP_AUIPC, OP_IMM, OP_IMM32, OP_REG, OP_REG32: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

    // NOTE: queue storage has no reset; cnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: if_instr, pc: if_pc};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr ^ pop;
            wr_ptr <= wr_ptr ^ push;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef DECODE_HAZARD_CHK_EN
    logic       ld_vld;
    logic [4:0] ld_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign rd  = head.instr[11:7];
    assign rs1 = head.instr[19:15];
    assign rs2 = head.instr[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_load  = 1'b0;
        case (head.instr[6:0])
            OP_LOAD:                    begin uses_rs1 = 1'b1; is_load = 1'b1; end
            OP_STORE, OP_BRANCH,
            OP_REG, OP_REG32:           begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_JALR, OP_IMM, OP_IMM32:  uses_rs1 = 1'b1;
            default:                    ;
        endcase
    end

    assign haz = ld_vld & not_empty &
                 ((uses_rs1 & (rs1 == ld_rd)) | (uses_rs2 & (rs2 == ld_rd)));

    // The tracker only advances when EX moves, so a stalled EX keeps the bubble alive.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_vld <= 1'b0;
            ld_rd  <= 5'd0;
        end else if (flush) begin
            ld_vld <= 1'b0;
        end else if (ex_ready) begin
            if (pop && is_load && (rd != 5'd0)) begin
                ld_vld <= 1'b1;
                ld_rd  <= rd;
            end else begin
                ld_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (haz && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign haz       = 1'b0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: directed streams, backpressure, load-use, flush, illegal opcodes, mid-stream reset.
module tb_decode_issue_ctrl;

    localparam int PC_W  = 64;
    localparam int CNT_W = 16;

`ifdef DECODE_HAZARD_CHK_EN
    localparam int LU_GAP   = 2;
    localparam int LU_STALL = 1;
`else
    localparam int LU_GAP   = 1;
    localparam int LU_STALL = 0;
`endif

    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic            ill;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [PC_W-1:0]  if_pc;
    logic             if_ready;
    logic             id_valid;
    logic [31:0]      id_instr;
    logic [PC_W-1:0]  id_pc;
    logic             id_illegal;
    logic             ex_ready;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    exp_t exp_q[$];
    int   issue_cyc[$];
    int   cyc = 0;
    int   last_push_cyc = 0;
    int   total = 0;
    int   bad = 0;

    decode_issue_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_illegal(id_illegal),
        .ex_ready(ex_ready), .flush(flush), .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Offer one word until accepted; only words expected to issue go into the scoreboard.
    task automatic offer(input logic [31:0] ins, input logic [PC_W-1:0] pc,
                         input logic ill, input logic issues);
        int n = 0;
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        @(negedge clk);
        while (!if_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_ready) begin
            total++;
            bad++;
            $display("FAIL offer_timeout: if_ready stuck at 0 for pc 0x%0h", pc);
        end else if (issues) begin
            exp_q.push_back('{instr: ins, pc: pc, ill: ill});
        end
        @(posedge clk);
        #1;
        last_push_cyc = cyc;
        if_valid = 1'b0;
    endtask

    // Monitor: every handshake pops the scoreboard and compares.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && ex_ready && !flush) begin
                issue_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_issue: got instr 0x%0h pc 0x%0h expected nothing", id_instr, id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_instr", 64'(id_instr), 64'(e.instr));
                    check("issue_pc", id_pc, e.pc);
                    check("issue_illegal", 64'(id_illegal), 64'(e.ill));
                end
            end
        end
    end

    logic [31:0] vec_instr [8];
    logic        vec_ill   [8];
    int          push0;

    initial begin
        vec_instr = '{32'h0000000B, 32'h000012B7, 32'h0000006F, 32'h0000003B,
                      32'h00000057, 32'h00008067, 32'h00000063, 32'h00002023};
        vec_ill   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        if_valid = 1'b0; if_instr = '0; if_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_if_ready", 64'(if_ready), 64'd1);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_instr", 64'(id_instr), 64'd0);
        check("rst_id_pc", id_pc, 64'd0);
        check("rst_id_illegal", 64'(id_illegal), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Back-to-back stream with one-cycle latency.
        @(posedge clk); #1;
        ex_ready = 1'b1;
        issue_cyc.delete();
        offer(32'h00100093, 64'h0, 1'b0, 1'b1);
        push0 = last_push_cyc;
        offer(32'h00200113, 64'h4, 1'b0, 1'b1);
        offer(32'h00300193, 64'h8, 1'b0, 1'b1);
        offer(32'h00400213, 64'hC, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("stream_count", 64'(issue_cyc.size()), 64'd4);
        foreach (issue_cyc[i]) check("stream_cycle", 64'(issue_cyc[i]), 64'(push0 + i));

        // Backpressure: third word waits for the first pop.
        @(posedge clk); #1;
        ex_ready = 1'b0;
        issue_cyc.delete();
        fork
            begin
                offer(32'h00500293, 64'h10, 1'b0, 1'b1);
                offer(32'h00600313, 64'h14, 1'b0, 1'b1);
                offer(32'h00700393, 64'h18, 1'b0, 1'b1);
            end
            begin
                repeat (4) @(negedge clk);
                check("full_if_ready", 64'(if_ready), 64'd0);
                check("full_id_valid", 64'(id_valid), 64'd1);
                check("full_head", 64'(id_instr), 64'h00500293);
                @(posedge clk); #1;
                ex_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("bp_count", 64'(issue_cyc.size()), 64'd3);

        // Load-use pair, then the same shape with rd = x0.
        @(posedge clk); #1;
        issue_cyc.delete();
        offer(32'h00013283, 64'h100, 1'b0, 1'b1);
        offer(32'h00128333, 64'h104, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("lu_count", 64'(issue_cyc.size()), 64'd2);
        if (issue_cyc.size() == 2) check("lu_gap", 64'(issue_cyc[1] - issue_cyc[0]), 64'(LU_GAP));
        check("lu_stall_cnt", 64'(stall_cnt), 64'(LU_STALL));

        @(posedge clk); #1;
        issue_cyc.delete();
        offer(32'h00013003, 64'h110, 1'b0, 1'b1);
        offer(32'h00100333, 64'h114, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("x0_count", 64'(issue_cyc.size()), 64'd2);
        if (issue_cyc.size() == 2) check("x0_gap", 64'(issue_cyc[1] - issue_cyc[0]), 64'd1);
        check("x0_stall_cnt", 64'(stall_cnt), 64'(LU_STALL));

        // Flush with a full queue and a same-cycle offer.
        @(posedge clk); #1;
        ex_ready = 1'b0;
        offer(32'h00800413, 64'h200, 1'b0, 1'b0);
        offer(32'h00900493, 64'h204, 1'b0, 1'b0);
        flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00A00513; if_pc = 64'h208;
        @(posedge clk); #1;
        flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("flush_id_valid", 64'(id_valid), 64'd0);
        check("flush_if_ready", 64'(if_ready), 64'd1);
        check("flush_id_instr", 64'(id_instr), 64'd0);
        check("flush_id_pc", id_pc, 64'd0);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        offer(32'h00500113, 64'h300, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check("flush_drained", 64'(exp_q.size()), 64'd0);

        // Illegal opcode held at the head, then a mixed opcode stream.
        @(posedge clk); #1;
        ex_ready = 1'b0;
        offer(32'h0000007F, 64'h400, 1'b1, 1'b1);
        @(negedge clk);
        check("ill_id_valid", 64'(id_valid), 64'd1);
        check("ill_id_illegal", 64'(id_illegal), 64'd1);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) offer(vec_instr[i], 64'h500 + 64'(4 * i), vec_ill[i], 1'b1);
        repeat (3) @(negedge clk);
        check("vec_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream overrides flush and traffic.
        @(posedge clk); #1;
        ex_ready = 1'b0;
        offer(32'h00B00593, 64'h600, 1'b0, 1'b0);
        offer(32'h00C00613, 64'h604, 1'b0, 1'b0);
        rst = 1'b1; flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00D00693; if_pc = 64'h608;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        check("mrst_id_valid", 64'(id_valid), 64'd0);
        check("mrst_if_ready", 64'(if_ready), 64'd1);
        check("mrst_id_instr", 64'(id_instr), 64'd0);
        check("mrst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("final_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
